seg_display_arbiter: RTL and testbench

Round-robin controller that shares the APB seven-segment display peripheral between up to N_REQ requesters. Each requester presents a 32-bit digit word (8 nibbles, digit1 in bits [3:0]). The block serialises these words into APB write transfers to the display's DIGITS register (offset 0x04). It also mirrors a level `display_on` input into the CONFIG register (offset 0x00, bit 0 = enable). It sits between the application logic and the display's APB slave port, as the only APB master on that port.

---
 rtl/seg_display_arbiter.sv | 161 ++++++++++++++++
 tb/tb_seg_display_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_arbiter.sv
// Round-robin APB master that shares the seven-segment display between requesters
// and mirrors the display_on level into the CONFIG register.
module seg_display_arbiter #(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned HOLD_CYCLES = 1000,
   parameter logic [31:0] BASE_ADDR   = 32'h0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [N_REQ-1:0]      req,
   input  logic [32*N_REQ-1:0]   req_value,
   input  logic                  display_on,
   output logic [N_REQ-1:0]      done,
   output logic                  err,
   output logic                  busy,
   output logic [31:0]           pADDR,
   output logic                  pSEL,
   output logic                  pENABLE,
   output logic                  pWRITE,
   output logic [31:0]           pWDATA,
   input  logic                  pREADY,
   input  logic                  pSLVERR
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
   localparam int unsigned PTR_W  = $clog2(N_REQ);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

   state_t              state_q, state_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [PTR_W-1:0]    win_q, win_d;
   logic                cfg_q, cfg_d;
   logic                shadow_q, shadow_d;
   logic [HOLD_W-1:0]   cnt_q, cnt_d;
   logic [31:0]         addr_d, wdata_d;
   logic                sel_d, en_d, err_d, busy_d;
   logic [N_REQ-1:0]    done_d;
   logic                found;
   logic [PTR_W-1:0]    win_sel;
   logic [DATA_W-1:0]   words [N_REQ];

   for (genvar g = 0; g < int'(N_REQ); g++) begin : g_words
      assign words[g] = req_value[g*DATA_W +: DATA_W];
   end

   // Next-state, arbitration and next output values.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      win_d    = win_q;
      cfg_d    = cfg_q;
      shadow_d = shadow_q;
      cnt_d    = cnt_q;
      addr_d   = pADDR;
      wdata_d  = pWDATA;
      sel_d    = 1'b0;
      en_d     = 1'b0;
      err_d    = 1'b0;
      done_d   = '0;
      found    = 1'b0;
      win_sel  = '0;

      // First requesting index at or above the pointer, wrapping around.
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (!found && req[PTR_W'((32'(ptr_q) + k) % N_REQ)]) begin
            found   = 1'b1;
            win_sel = PTR_W'((32'(ptr_q) + k) % N_REQ);
         end
      end

      unique case (state_q)
         IDLE: begin
            if (display_on != shadow_q) begin
               cfg_d   = 1'b1;
               addr_d  = BASE_ADDR;
               wdata_d = {{(DATA_W-1){1'b0}}, display_on};
               sel_d   = 1'b1;
               state_d = SETUP;
            end else if (found) begin
               cfg_d   = 1'b0;
               win_d   = win_sel;
               addr_d  = BASE_ADDR + 32'd4;
               wdata_d = words[win_sel];
               ptr_d   = (win_sel == PTR_W'(N_REQ - 1)) ? '0 : win_sel + PTR_W'(1);
               sel_d   = 1'b1;
               state_d = SETUP;
            end
         end
         SETUP: begin
            sel_d   = 1'b1;
            en_d    = 1'b1;
            state_d = ACCESS;
         end
         ACCESS: begin
            if (pREADY) begin
               err_d = pSLVERR;
               if (cfg_q) begin
                  shadow_d = pWDATA[0];
                  state_d  = IDLE;
               end else begin
                  done_d[win_q] = 1'b1;
                  if (HOLD_CYCLES > 0) begin
                     cnt_d   = HOLD_W'(HOLD_CYCLES);
                     state_d = HOLD;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end else begin
               sel_d = 1'b1;
               en_d  = 1'b1;
            end
         end
         HOLD: begin
            if (cnt_q != '0) cnt_d = cnt_q - HOLD_W'(1);
            if (cnt_q <= HOLD_W'(1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         win_q    <= '0;
         cfg_q    <= 1'b0;
         shadow_q <= 1'b0;
         cnt_q    <= '0;
         pADDR    <= '0;
         pWDATA   <= '0;
         pSEL     <= 1'b0;
         pENABLE  <= 1'b0;
         pWRITE   <= 1'b0;
         done     <= '0;
         err      <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         win_q    <= win_d;
         cfg_q    <= cfg_d;
         shadow_q <= shadow_d;
         cnt_q    <= cnt_d;
         pADDR    <= addr_d;
         pWDATA   <= wdata_d;
         pSEL     <= sel_d;
         pENABLE  <= en_d;
         pWRITE   <= sel_d;
         done     <= done_d;
         err      <= err_d;
         busy     <= busy_d;
      end
   end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter: APB writes are scoreboarded in issue order,
// done/err/timing are checked at fixed cycles.
module tb_seg_display_arbiter;

   localparam int unsigned N = 4;
   localparam int unsigned H = 4;

   logic            clock;
   logic            reset;
   logic [N-1:0]    req;
   logic [32*N-1:0] req_value;
   logic            display_on;
   logic [N-1:0]    done;
   logic            err;
   logic            busy;
   logic [31:0]     pADDR;
   logic            pSEL;
   logic            pENABLE;
   logic            pWRITE;
   logic [31:0]     pWDATA;
   logic            pREADY;
   logic            pSLVERR;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  n_tests;
   int  n_fail;
   int  cyc;

   seg_display_arbiter #(.N_REQ(N), .HOLD_CYCLES(H), .BASE_ADDR(32'h0)) dut (
      .clock(clock), .reset(reset), .req(req), .req_value(req_value),
      .display_on(display_on), .done(done), .err(err), .busy(busy),
      .pADDR(pADDR), .pSEL(pSEL), .pENABLE(pENABLE), .pWRITE(pWRITE),
      .pWDATA(pWDATA), .pREADY(pREADY), .pSLVERR(pSLVERR)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic set_val(input int i, input logic [31:0] v);
      req_value[i*32 +: 32] = v;
   endtask

   // Mid-cycle sample: completed APB writes are popped from the scoreboard.
   task automatic mon();
      wr_t e;
      chk("pwrite_eq_psel", 32'(pWRITE), 32'(pSEL));
      if (pSEL && pENABLE && pREADY) begin
         chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("wr_addr", pADDR, e.addr);
            chk("wr_data", pWDATA, e.data);
         end
      end
   endtask

   task automatic tick();
      @(negedge clock);
      mon();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic wait_idle(input string tag, input int limit);
      int i;
      i = 0;
      while (busy && i < limit) begin
         tick();
         i++;
      end
      chk(tag, 32'(busy), 32'd0);
   endtask

   task automatic wait_done(input string tag, input int limit);
      int i;
      i = 0;
      tick();
      while (done == '0 && i < limit) begin
         tick();
         i++;
      end
      chk(tag, 32'(done != '0), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int start;
      int prev;
      n_tests    = 0;
      n_fail     = 0;
      cyc        = 0;
      reset      = 1'b1;
      req        = '0;
      req_value  = '0;
      display_on = 1'b1;
      pREADY     = 1'b1;
      pSLVERR    = 1'b0;
      repeat (3) tick();

      chk("rst_psel",    32'(pSEL),    32'd0);
      chk("rst_penable", 32'(pENABLE), 32'd0);
      chk("rst_paddr",   pADDR,        32'd0);
      chk("rst_pwdata",  pWDATA,       32'd0);
      chk("rst_done",    32'(done),    32'd0);
      chk("rst_err",     32'(err),     32'd0);
      chk("rst_busy",    32'(busy),    32'd0);

      // CONFIG write after reset with display_on already high
      reset = 1'b0;
      push(32'h0, 32'h1);
      tick();
      chk("cfg_setup_sel",  32'(pSEL),    32'd1);
      chk("cfg_setup_en",   32'(pENABLE), 32'd0);
      chk("cfg_setup_addr", pADDR,        32'h0);
      chk("cfg_setup_data", pWDATA,       32'h1);
      chk("cfg_setup_busy", 32'(busy),    32'd1);
      tick();
      chk("cfg_access_sel", 32'(pSEL),    32'd1);
      chk("cfg_access_en",  32'(pENABLE), 32'd1);
      tick();
      chk("cfg_end_sel",  32'(pSEL), 32'd0);
      chk("cfg_end_done", 32'(done), 32'd0);
      chk("cfg_end_err",  32'(err),  32'd0);
      chk("cfg_end_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("cfg_quiet_sel", 32'(pSEL), 32'd0);
      end

      // Single requester latency; value changes after grant are ignored
      req = 4'b0100;
      set_val(2, 32'h12345678);
      push(32'h4, 32'h12345678);
      tick();
      chk("lat_c1_sel", 32'(pSEL), 32'd1);
      set_val(2, 32'hFFFF0000);
      tick();
      chk("lat_c2_done", 32'(done), 32'd0);
      tick();
      chk("lat_c3_done", 32'(done), 32'b0100);
      chk("lat_c3_busy", 32'(busy), 32'd1);
      req = '0;
      tick();
      chk("lat_c4_done", 32'(done), 32'd0);
      wait_idle("lat_idle", 20);

      // Wait states followed by a slave error
      pREADY = 1'b0;
      req    = 4'b0010;
      set_val(1, 32'hDEADBEEF);
      push(32'h4, 32'hDEADBEEF);
      for (int c = 1; c <= 5; c++) begin
         tick();
         if (c == 5) begin
            pREADY  = 1'b1;
            pSLVERR = 1'b1;
         end
         chk("ws_sel",  32'(pSEL),    32'd1);
         chk("ws_en",   32'(pENABLE), 32'(c >= 2));
         chk("ws_addr", pADDR,        32'h4);
         chk("ws_data", pWDATA,       32'hDEADBEEF);
         chk("ws_done", 32'(done),    32'd0);
         chk("ws_err",  32'(err),     32'd0);
      end
      tick();
      chk("ws_end_done", 32'(done), 32'b0010);
      chk("ws_end_err",  32'(err),  32'd1);
      chk("ws_end_sel",  32'(pSEL), 32'd0);
      pSLVERR = 1'b0;
      req     = '0;
      tick();
      chk("ws_err_clr",  32'(err),  32'd0);
      chk("ws_done_clr", 32'(done), 32'd0);
      wait_idle("ws_idle", 20);

      // Reset asserted while in ACCESS abandons the transfer
      pREADY = 1'b0;
      req    = 4'b1000;
      set_val(3, 32'h00000077);
      tick();
      tick();
      chk("rm_in_access", 32'(pENABLE), 32'd1);
      reset      = 1'b1;
      req        = '0;
      display_on = 1'b0;
      tick();
      chk("rm_sel",  32'(pSEL),    32'd0);
      chk("rm_en",   32'(pENABLE), 32'd0);
      chk("rm_busy", 32'(busy),    32'd0);
      chk("rm_done", 32'(done),    32'd0);
      chk("rm_err",  32'(err),     32'd0);
      reset  = 1'b0;
      pREADY = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rm_quiet_done", 32'(done), 32'd0);
         chk("rm_quiet_sel",  32'(pSEL), 32'd0);
      end

      // All requesters held: round-robin from requester 0
      req = 4'hF;
      for (int i = 0; i < 4; i++) set_val(i, 32'hA0A00000 + 32'(i));
      for (int k = 0; k < 5; k++) push(32'h4, 32'hA0A00000 + 32'(k % 4));
      start = cyc;
      prev  = start;
      for (int k = 0; k < 5; k++) begin
         wait_done("rr_timeout", 20);
         chk("rr_order", 32'(done), 32'(1 << (k % 4)));
         chk("rr_gap",   32'(cyc - prev), (k == 0) ? 32'd3 : 32'(3 + H));
         prev = cyc;
      end
      req = '0;
      wait_idle("rr_idle", 20);

      // display_on rises during a DIG access: CONFIG precedes pending requester 1
      req = 4'b0001;
      set_val(0, 32'h00000055);
      push(32'h4, 32'h00000055);
      push(32'h0, 32'h00000001);
      push(32'h4, 32'h00000066);
      tick();
      req = 4'b0011;
      set_val(1, 32'h00000066);
      tick();
      chk("pc_access", 32'(pENABLE), 32'd1);
      display_on = 1'b1;
      wait_done("pc_d0_timeout", 20);
      chk("pc_d0", 32'(done), 32'b0001);
      req = 4'b0010;
      wait_done("pc_d1_timeout", 30);
      chk("pc_d1", 32'(done), 32'b0010);
      chk("pc_all_writes", 32'(exp_q.size()), 32'd0);
      req = '0;

      // Toggle and restore display_on during HOLD: no CONFIG write
      display_on = 1'b0;
      tick();
      display_on = 1'b1;
      wait_idle("tg_idle", 20);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("tg_quiet_sel", 32'(pSEL), 32'd0);
      end
      chk("tg_no_extra", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
